// File: rtl/pc_pkg.sv
// pc_pkg: opcodes, branch conditions, flag indices and FSM states shared by next_ip_unit
package pc_pkg;
  localparam logic [4:0] OP_HALT = 5'b00001;
  localparam logic [4:0] OP_JMP  = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b01101;
  localparam logic [4:0] OP_CALL = 5'b01110;
  localparam logic [4:0] OP_RET  = 5'b01111;
  localparam logic [2:0] CC_AL = 3'b000;
  localparam logic [2:0] CC_Z  = 3'b001;
  localparam logic [2:0] CC_NZ = 3'b010;
  localparam logic [2:0] CC_N  = 3'b011;
  localparam logic [2:0] CC_NN = 3'b100;
  localparam logic [2:0] CC_C  = 3'b101;
  localparam logic [2:0] CC_NC = 3'b110;
  localparam logic [2:0] CC_V  = 3'b111;
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;
  function automatic logic cond_ok(input logic [2:0] cc, input logic [3:0] f);
    return cc == CC_AL ? 1'b1 :
           cc == CC_Z  ? f[FLG_Z] :
           cc == CC_NZ ? !f[FLG_Z] :
           cc == CC_N  ? f[FLG_N] :
           cc == CC_NN ? !f[FLG_N] :
           cc == CC_C  ? f[FLG_C] :
           cc == CC_NC ? !f[FLG_C] : f[FLG_V];
  endfunction
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address LIFO; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int DW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [15:0]   din_i,
  output logic [15:0]   top_o,
  output logic [DW-1:0] depth_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] sp_q, sp_d, top_idx;
  logic [DW-1:0] depth_q, depth_d;
  assign top_idx = sp_q - 1'b1;
  assign top_o   = mem[top_idx];
  assign full_o  = depth_q == DW'(DEPTH);
  assign empty_o = depth_q == '0;
  assign depth_o = depth_q;
  assign sp_d    = push_i ? sp_q + 1'b1 : pop_i ? sp_q - 1'b1 : sp_q;
  assign depth_d = push_i ? (full_o ? depth_q : depth_q + 1'b1) : pop_i ? depth_q - 1'b1 : depth_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  always_ff @(posedge clk)
    if (push_i) mem[sp_q] <= din_i;
endmodule

// File: rtl/next_ip_unit.sv
// next_ip_unit: next-fetch-address select with return stack and RUN/HALT FSM; PC_TRAP_EN traps RAS over/underflow
module next_ip_unit
  import pc_pkg::*;
#(
  parameter int          RAS_DEPTH = 8,
  parameter logic [15:0] TRAP_VEC  = 16'h0002
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                ip,
  input  logic [15:0]                inst,
  input  logic [3:0]                 flags,
  input  logic                       stall,
  input  logic                       resume,
  output logic [15:0]                next_ip,
  output logic                       halted,
  output logic [$clog2(RAS_DEPTH):0] ras_depth,
  output logic                       ras_ovf,
  output logic                       ras_unf
);
`ifdef PC_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif
  state_e      state_q, state_d;
  logic        ovf_q, ovf_d, unf_q, unf_d;
  logic [4:0]  op;
  logic [15:0] seq, jtgt, btgt, top, run_sel;
  logic        run, is_call, is_ret, full, empty, push, pop;
  assign op      = inst[15:11];
  assign seq     = ip + 16'd1;
  assign jtgt    = {ip[15:11], inst[10:0]};
  assign btgt    = seq + {{8{inst[7]}}, inst[7:0]};
  assign run     = state_q == ST_RUN && !stall;
  assign is_call = run && op == OP_CALL;
  assign is_ret  = run && op == OP_RET;
  assign push    = is_call && !(TRAP_EN && full);
  assign pop     = is_ret && !empty;
  assign run_sel = op == OP_HALT ? ip :
                   op == OP_JMP  ? jtgt :
                   op == OP_BR   ? (cond_ok(inst[10:8], flags) ? btgt : seq) :
                   op == OP_CALL ? (TRAP_EN && full ? TRAP_VEC : jtgt) :
                   op == OP_RET  ? (empty ? (TRAP_EN ? TRAP_VEC : seq) : top) : seq;
  assign next_ip = stall ? ip : state_q == ST_HALT ? (resume ? seq : ip) : run_sel;
  assign state_d = stall ? state_q :
                   state_q == ST_HALT ? (resume ? ST_RUN : ST_HALT) :
                   op == OP_HALT ? ST_HALT : ST_RUN;
  assign ovf_d   = ovf_q || (is_call && full);
  assign unf_d   = unf_q || (is_ret && empty);
  assign halted  = state_q == ST_HALT;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_RUN;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  ras_stack #(.DEPTH(RAS_DEPTH), .DW($clog2(RAS_DEPTH) + 1)) u_ras (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .din_i(seq),
    .top_o(top), .depth_o(ras_depth), .full_o(full), .empty_o(empty)
  );
endmodule
